// File: rtl/vmask_set_first_pkg.sv
// Shared types and helpers for the vmsbf/vmsif/vmsof mask-op lane.
// Related build option: VMASK_SET_FIRST_MASKED_EN (masked operation ports).
package vmsxf_pkg;

   typedef enum logic [1:0] {
      OP_SBF = 2'd0,
      OP_SIF = 2'd1,
      OP_SOF = 2'd2
   } op_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } state_e;

   // Widest chunk the thermometer helper can describe; callers truncate to their own width.
   localparam int unsigned MAX_WIDTH = 1024;

   function automatic logic [MAX_WIDTH-1:0] len_to_mask(input int unsigned len);
      logic [MAX_WIDTH-1:0] ones;
      ones = '1;
      return ~(ones << len);
   endfunction

endpackage

// File: rtl/vmask_set_first_if.sv
// Chunk stream bundle for vmask_set_first: source chunk in, destination chunk out.
// VMASK_SET_FIRST_MASKED_EN adds the v0 mask and old-destination inputs.
interface vmask_set_first_if #(
   parameter int DATA_WIDTH = 64
);
   localparam int LEN_W = $clog2(DATA_WIDTH + 1);

   logic                  in_valid;
   logic                  in_start;
   logic                  in_last;
   logic [1:0]            in_op;
   logic [LEN_W-1:0]      in_len;
   logic [DATA_WIDTH-1:0] in_m0;
`ifdef VMASK_SET_FIRST_MASKED_EN
   logic                  in_vm;
   logic [DATA_WIDTH-1:0] in_v0;
   logic [DATA_WIDTH-1:0] in_vd_old;
`endif
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_vec;
   logic                  out_found;

   modport master (
`ifdef VMASK_SET_FIRST_MASKED_EN
      output in_vm, in_v0, in_vd_old,
`endif
      output in_valid, in_start, in_last, in_op, in_len, in_m0,
      input  out_valid, out_vec, out_found
   );

   modport slave (
`ifdef VMASK_SET_FIRST_MASKED_EN
      input  in_vm, in_v0, in_vd_old,
`endif
      input  in_valid, in_start, in_last, in_op, in_len, in_m0,
      output out_valid, out_vec, out_found
   );

endinterface

// File: rtl/vmask_set_first_lowbit_isolate.sv
// Isolates the lowest set bit of a vector and reports whether any bit is set.
module lowbit_isolate #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] vec,
   output logic [WIDTH-1:0] iso,
   output logic             hit
);

   always_comb begin
      iso = vec & (~vec + WIDTH'(1));
      hit = |vec;
   end

endmodule

// File: rtl/vmask_set_first.sv
// Streaming vmsbf.m / vmsif.m / vmsof.m generator with one-cycle registered latency.
// Define VMASK_SET_FIRST_MASKED_EN for masked operation (v0 / mask-undisturbed vd_old).
module vmask_set_first
   import vmsxf_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input logic              clk,
   input logic              rst,
   vmask_set_first_if.slave bus
);

   logic [DATA_WIDTH-1:0] lenmask;
   logic [DATA_WIDTH-1:0] active;
   logic [DATA_WIDTH-1:0] eff;
   logic [DATA_WIDTH-1:0] iso;
   logic                  hit;
   logic                  prior_done;
   logic [DATA_WIDTH-1:0] op_vec;
   logic [DATA_WIDTH-1:0] body_vec;
   logic [DATA_WIDTH-1:0] chunk_vec;
   logic                  chunk_found;

   state_e                state_q, state_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_vec_q, out_vec_d;
   logic                  out_found_q, out_found_d;

   // Active lanes: body elements, further restricted by v0 when masked.
   always_comb begin
      lenmask = DATA_WIDTH'(len_to_mask(32'(bus.in_len)));
`ifdef VMASK_SET_FIRST_MASKED_EN
      active  = bus.in_vm ? lenmask : (lenmask & bus.in_v0);
`else
      active  = lenmask;
`endif
      eff     = bus.in_m0 & active;
   end

   lowbit_isolate #(
      .WIDTH (DATA_WIDTH)
   ) u_lowbit (
      .vec (eff),
      .iso (iso),
      .hit (hit)
   );

   always_comb begin
      // A start chunk discards any earlier find, so only a continuing op sees DONE.
      prior_done = (state_q == DONE) && !bus.in_start;

      case (bus.in_op)
         OP_SBF:  op_vec = hit ? (iso - DATA_WIDTH'(1)) : '1;
         OP_SIF:  op_vec = hit ? ((iso - DATA_WIDTH'(1)) | iso) : '1;
         default: op_vec = iso;
      endcase

      body_vec = prior_done ? '0 : op_vec;
`ifdef VMASK_SET_FIRST_MASKED_EN
      chunk_vec = (body_vec & active) | (bus.in_vd_old & lenmask & ~active);
`else
      chunk_vec = body_vec & active;
`endif
      chunk_found = hit | prior_done;
   end

   always_comb begin
      state_d     = state_q;
      out_valid_d = bus.in_valid;
      out_vec_d   = '0;
      out_found_d = 1'b0;

      if (bus.in_valid) begin
         out_vec_d   = chunk_vec;
         out_found_d = chunk_found;
         if (bus.in_last) begin
            state_d = IDLE;
         end else if (chunk_found) begin
            state_d = DONE;
         end else begin
            state_d = SEARCH;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         out_vec_q   <= '0;
         out_found_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_vec_q   <= out_vec_d;
         out_found_q <= out_found_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_vec   = out_vec_q;
   assign bus.out_found = out_found_q;

endmodule

// File: tb/tb_vmask_set_first.sv
// Scoreboard bench for vmask_set_first at DATA_WIDTH=8: directed cases plus randomized ops vs a bit-level model.
module tb_vmask_set_first;

   localparam int W     = 8;
   localparam int LEN_W = $clog2(W + 1);

   logic clk;
   logic rst;

   vmask_set_first_if #(.DATA_WIDTH(W)) bus ();

   vmask_set_first #(.DATA_WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         due;
      logic [W-1:0] vec;
      logic       found;
      string      name;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   bit   m_done = 1'b0;

   // Monitor: each cycle either the head expectation is due (valid output) or the output must be idle zeros.
   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      if (q.size() > 0 && q[0].due == cyc) begin
         exp_t e;
         e = q.pop_front();
         checks = checks + 3;
         if (bus.out_valid !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL %s valid: got %b want 1", e.name, bus.out_valid);
         end
         if (bus.out_vec !== e.vec) begin
            errors = errors + 1;
            $display("FAIL %s vec: got %h want %h", e.name, bus.out_vec, e.vec);
         end
         if (bus.out_found !== e.found) begin
            errors = errors + 1;
            $display("FAIL %s found: got %b want %b", e.name, bus.out_found, e.found);
         end
         $display("cyc %0d %s vec=%h found=%b", cyc, e.name, bus.out_vec, bus.out_found);
      end else begin
         checks = checks + 1;
         if (bus.out_valid !== 1'b0 || bus.out_vec !== '0 || bus.out_found !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL idle_zero cyc %0d: got valid=%b vec=%h found=%b want 0/00/0",
                     cyc, bus.out_valid, bus.out_vec, bus.out_found);
         end
      end
   end

   // Reference: locate the first active set element, then shape every lane by position relative to it.
   task automatic model(input logic [1:0] op, input int len, input logic [W-1:0] m0,
                        input bit start, input bit last, input bit vm,
                        input logic [W-1:0] v0, input logic [W-1:0] vd_old,
                        output logic [W-1:0] vec, output logic found);
      int first;
      bit prior;
      bit act;
      first = -1;
      prior = m_done && !start;
      for (int i = 0; i < W; i++) begin
`ifdef VMASK_SET_FIRST_MASKED_EN
         act = vm || v0[i];
`else
         act = 1'b1;
`endif
         if (i < len && act && m0[i] && first < 0) first = i;
      end
      for (int i = 0; i < W; i++) begin
`ifdef VMASK_SET_FIRST_MASKED_EN
         act = vm || v0[i];
`else
         act = 1'b1;
`endif
         if (i >= len)       vec[i] = 1'b0;
         else if (!act)      vec[i] = vd_old[i];
         else if (prior)     vec[i] = 1'b0;
         else if (op == 2'd0) vec[i] = (first < 0) || (i < first);
         else if (op == 2'd1) vec[i] = (first < 0) || (i <= first);
         else                vec[i] = (i == first);
      end
      found  = (first >= 0) || prior;
      m_done = last ? 1'b0 : found;
   endtask

   task automatic send(input logic [1:0] op, input int len, input logic [W-1:0] m0,
                       input bit start, input bit last, input bit vm,
                       input logic [W-1:0] v0, input logic [W-1:0] vd_old,
                       input bit use_exp, input logic [W-1:0] exp_vec, input logic exp_found,
                       input string name);
      exp_t e;
      logic [W-1:0] mv;
      logic mf;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_start = start;
      bus.in_last  = last;
      bus.in_op    = op;
      bus.in_len   = LEN_W'(len);
      bus.in_m0    = m0;
`ifdef VMASK_SET_FIRST_MASKED_EN
      bus.in_vm     = vm;
      bus.in_v0     = v0;
      bus.in_vd_old = vd_old;
`endif
      model(op, len, m0, start, last, vm, v0, vd_old, mv, mf);
      e.due   = cyc + 1;
      e.vec   = use_exp ? exp_vec : mv;
      e.found = use_exp ? exp_found : mf;
      e.name  = name;
      q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         bus.in_m0    = W'($urandom);
      end
   endtask

   // Directed chunk with a hand-derived expectation, unmasked.
   task automatic dsend(input logic [1:0] op, input int len, input logic [W-1:0] m0,
                        input bit start, input bit last,
                        input logic [W-1:0] ev, input logic ef, input string name);
      send(op, len, m0, start, last, 1'b1, '1, '0, 1'b1, ev, ef, name);
   endtask

   initial begin
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_start = 1'b0;
      bus.in_last  = 1'b0;
      bus.in_op    = 2'd0;
      bus.in_len   = '0;
      bus.in_m0    = '0;
`ifdef VMASK_SET_FIRST_MASKED_EN
      bus.in_vm     = 1'b1;
      bus.in_v0     = '0;
      bus.in_vd_old = '0;
`endif
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle(1);

      dsend(2'd0, 8, 8'h28, 1, 1, 8'h07, 1'b1, "sbf_single");
      idle(1);
      dsend(2'd1, 8, 8'h00, 1, 0, 8'hFF, 1'b0, "sif_c0");
      dsend(2'd1, 8, 8'h04, 0, 0, 8'h07, 1'b1, "sif_c1");
      dsend(2'd1, 8, 8'hFF, 0, 1, 8'h00, 1'b1, "sif_c2");
      dsend(2'd2, 8, 8'h10, 1, 0, 8'h10, 1'b1, "sof_c0");
      dsend(2'd2, 8, 8'hFF, 0, 0, 8'h00, 1'b1, "sof_c1");
      dsend(2'd2, 8, 8'h01, 0, 1, 8'h00, 1'b1, "sof_c2");
      // Back in IDLE: a non-start chunk must search afresh rather than inherit the find.
      dsend(2'd0, 8, 8'h00, 0, 1, 8'hFF, 1'b0, "after_last_idle");
      dsend(2'd0, 4, 8'hF0, 1, 1, 8'h0F, 1'b0, "tail_sbf_len4");
      dsend(2'd2, 0, 8'hFF, 1, 1, 8'h00, 1'b0, "tail_sof_len0");
      dsend(2'd3, 8, 8'h0C, 1, 1, 8'h04, 1'b1, "op3_as_sof");
      dsend(2'd1, 8, 8'h01, 1, 0, 8'h01, 1'b1, "restart_a");
      dsend(2'd0, 8, 8'h40, 1, 1, 8'h3F, 1'b1, "restart_b");

      // Reset arrives while chunk 2 of an op is on the bus; that chunk must produce nothing.
      dsend(2'd1, 8, 8'h00, 1, 0, 8'hFF, 1'b0, "abort_c0");
      @(negedge clk);
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_start = 1'b0;
      bus.in_m0    = 8'h04;
      @(negedge clk);
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      m_done       = 1'b0;
      dsend(2'd1, 8, 8'h02, 1, 1, 8'h03, 1'b1, "post_reset_sif");
      idle(1);

`ifdef VMASK_SET_FIRST_MASKED_EN
      send(2'd2, 8, 8'h06, 1, 1, 1'b0, 8'hAA, 8'h55, 1'b1, 8'h57, 1'b1, "masked_sof");
      idle(1);
`endif

      for (int op_i = 0; op_i < 250; op_i++) begin
         int          nch;
         logic [1:0]  op;
         nch = int'($urandom_range(1, 4));
         op  = 2'($urandom_range(0, 3));
         for (int c = 0; c < nch; c++) begin
            int          len;
            int          mode;
            logic [W-1:0] m0;
            bit          start;
            len   = ($urandom_range(0, 1) == 1) ? W : int'($urandom_range(0, W));
            mode  = int'($urandom_range(0, 3));
            m0    = (mode == 0) ? '0 :
                    (mode == 1) ? W'($urandom & $urandom & $urandom) : W'($urandom);
            start = (c == 0) ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 15) == 0);
            send(op, len, m0, start, c == nch - 1, 1'($urandom), W'($urandom), W'($urandom),
                 1'b0, '0, 1'b0, $sformatf("rnd%0d_c%0d", op_i, c));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
         end
      end

      idle(4);
      checks = checks + 1;
      if (q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL drain: got %0d pending outputs want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
